// File: rtl/apb_master.sv
// Purpose : APB requester; turns one command-channel request into an APB SETUP/ACCESS transfer
// Latency : accept edge N -> SETUP in cycle N+1 -> first ACCESS in N+2 -> response in N+3 (zero wait)
// Backpr. : one transfer in flight; cmd_ready stays low until the response is taken via rsp_ready
//
// Ports:
//   pclk, preset                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready                command handshake (cmd_write, cmd_addr, cmd_wdata)
//   rsp_valid/rsp_ready                response handshake (rsp_rdata, rsp_err)
//   paddr, pwdata, pwrite, psel,       APB requester side
//   penable, prdata, pready, pslverr
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
  logic              cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d, pwdata_d;
  logic [ADDR_W-1:0] paddr_d;
  logic              pwrite_d, psel_d, penable_d;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_cnt_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      pwrite    <= pwrite_d;
      psel      <= psel_d;
      penable   <= penable_d;
    end
  end

  always_comb begin
    state_d     = state;
    wait_cnt_d  = wait_cnt;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    pwrite_d    = pwrite;
    psel_d      = psel;
    penable_d   = penable;

    case (state)
      IDLE: begin
        // cmd_ready comes up one edge after reset release and stays up here.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          pwrite_d    = cmd_write;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          // prdata is only looked at on the completing edge, so a floating
          // bus at any other time never reaches the response register.
          rsp_rdata_d = (pwrite || pslverr) ? '0 : prdata;
          rsp_err_d   = pslverr;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
          // Abort once pready has been low on TIMEOUT consecutive ACCESS edges.
          if (TIMEOUT != 0 && wait_cnt_d == CNT_W'(TIMEOUT)) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_d     = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Purpose : self-checking bench for apb_master with a behavioural APB register slave
// Latency : expected timing derived from the transfer rules (setup + access cycles + response)
// Backpr. : response channel is stalled for random numbers of cycles
module tb_apb_master;

  localparam int TMO = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  // Slave configuration for the current transfer.
  int   cfg_wait;
  logic cfg_err;
  int   slv_cnt;

  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  typedef struct packed {
    logic        hung;
    int          lat;
    int          acc;
    logic        stable;
    logic        s_psel;
    logic        s_pen;
    logic        s_wr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [31:0] r_data;
    logic        r_err;
    logic        held;
    logic        done_ok;
  } obs_t;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Register slave: inserts cfg_wait wait states, then completes (or errors).
  // Outside a completing ACCESS cycle prdata floats and pready/pslverr are noise.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (slv_cnt >= cfg_wait) begin
        pready  = 1'b1;
        pslverr = cfg_err;
        prdata  = cfg_err ? $urandom : slv_mem[paddr[5:2]];
        if (pwrite && !cfg_err) slv_mem[paddr[5:2]] = pwdata;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = 'z;
      end
      slv_cnt++;
    end else begin
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'b0;
      prdata  = 'z;
      slv_cnt = 0;
    end
  end

  // Reference model: outcome of one transfer from the protocol rules alone.
  function automatic void predict(input logic wr, input logic [31:0] rd_val, input int wait_n,
                                  input logic err, output logic [31:0] e_rdata,
                                  output logic e_err, output int e_acc);
    logic tmo;
    tmo     = (TMO != 0) && (wait_n >= TMO);
    e_acc   = tmo ? TMO : wait_n + 1;
    e_err   = tmo || err;
    e_rdata = (wr || e_err) ? 32'h0 : rd_val;
  endfunction

  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int wait_n, input logic err, input int rsp_delay,
                          output obs_t o);
    int guard;
    o = '0;
    o.stable = 1'b1;
    o.held   = 1'b1;
    cfg_wait  = wait_n;
    cfg_err   = err;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    rsp_ready = (rsp_delay == 0);
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge pclk);
      guard++;
    end
    if (guard >= 50) o.hung = 1'b1;
    @(negedge pclk);
    // Scramble the command bus to show the transfer uses latched values.
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_write = ~wr;
    o.s_psel  = psel;
    o.s_pen   = penable;
    o.s_wr    = pwrite;
    o.s_addr  = paddr;
    o.s_wdata = pwdata;
    o.lat = 1;
    while (rsp_valid !== 1'b1 && o.lat < 100) begin
      @(negedge pclk);
      o.lat++;
      if (psel && penable) begin
        o.acc++;
        if (paddr !== addr || pwrite !== wr || pwdata !== wdata || psel !== 1'b1) o.stable = 1'b0;
      end
    end
    if (o.lat >= 100) o.hung = 1'b1;
    o.r_data = rsp_rdata;
    o.r_err  = rsp_err;
    if (cmd_ready !== 1'b0) o.held = 1'b0;
    for (int k = 0; k < rsp_delay; k++) begin
      cmd_valid = 1'b1;
      @(negedge pclk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== o.r_data || rsp_err !== o.r_err ||
          cmd_ready !== 1'b0 || psel !== 1'b0) o.held = 1'b0;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    o.done_ok = (rsp_valid === 1'b0 && cmd_ready === 1'b1 && rsp_err === 1'b0 && psel === 1'b0);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge pclk);
    n_checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: psel/pen/pwr/rvld/rerr/crdy=%b required 000000",
               {psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready});
    end
    n_checks++;
    if (paddr !== 32'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h required all 0", paddr, pwdata, rsp_rdata);
    end
    preset = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_rdy_early: cmd_ready=%b required 0", cmd_ready);
    end
    @(negedge pclk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_rdy: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_zero_wait_write;
    obs_t o; logic [31:0] er; logic ee; int ea;
    predict(1'b1, ref_mem[1], 0, 1'b0, er, ee, ea);
    run_xfer(1'b1, 32'h4, 32'h1234_5678, 0, 1'b0, 0, o);
    if (!ee) ref_mem[1] = 32'h1234_5678;
    n_checks++;
    if (o.hung !== 1'b0) begin n_errors++; $display("FAIL zw_hung: hung=%b required 0", o.hung); end
    n_checks++;
    if ({o.s_psel, o.s_pen, o.s_wr} !== 3'b101 || o.s_addr !== 32'h4 || o.s_wdata !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL zw_setup: psel/pen/pwr=%b paddr=%h pwdata=%h required 101 4 12345678",
               {o.s_psel, o.s_pen, o.s_wr}, o.s_addr, o.s_wdata);
    end
    n_checks++;
    if (o.acc !== ea || o.lat !== ea + 2) begin
      n_errors++;
      $display("FAIL zw_timing: access=%0d lat=%0d required %0d %0d", o.acc, o.lat, ea, ea + 2);
    end
    n_checks++;
    if (o.r_err !== ee || o.r_data !== er || o.done_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL zw_rsp: err=%b data=%h done=%b required %b %h 1", o.r_err, o.r_data, o.done_ok, ee, er);
    end
  endtask

  task automatic test_read_reg;
    obs_t o; logic [31:0] er; logic ee; int ea;
    predict(1'b0, ref_mem[2], 0, 1'b0, er, ee, ea);
    run_xfer(1'b0, 32'h8, 32'h0, 0, 1'b0, 1, o);
    n_checks++;
    if (o.r_data !== er || o.r_data !== 32'hface_5678 || o.r_err !== 1'b0) begin
      n_errors++;
      $display("FAIL rd_reg: data=%h err=%b required face5678 0", o.r_data, o.r_err);
    end
    n_checks++;
    if (o.acc !== ea || o.lat !== ea + 2 || o.done_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL rd_timing: access=%0d lat=%0d done=%b required %0d %0d 1", o.acc, o.lat, o.done_ok, ea, ea + 2);
    end
  endtask

  task automatic test_wait_states;
    obs_t o; logic [31:0] er; logic ee; int ea;
    run_xfer(1'b1, 32'h30, 32'hCAFE_0001, 0, 1'b0, 0, o);
    ref_mem[12] = 32'hCAFE_0001;
    predict(1'b0, ref_mem[12], 3, 1'b0, er, ee, ea);
    run_xfer(1'b0, 32'h30, 32'h0, 3, 1'b0, 0, o);
    n_checks++;
    if (o.acc !== 4 || o.acc !== ea || o.stable !== 1'b1) begin
      n_errors++;
      $display("FAIL ws_access: access=%0d stable=%b required 4 1", o.acc, o.stable);
    end
    n_checks++;
    if (o.r_data !== er || o.r_err !== ee || o.lat !== ea + 2) begin
      n_errors++;
      $display("FAIL ws_rsp: data=%h err=%b lat=%0d required %h %b %0d", o.r_data, o.r_err, o.lat, er, ee, ea + 2);
    end
  endtask

  task automatic test_timeout;
    obs_t o; logic [31:0] er; logic ee; int ea;
    predict(1'b0, ref_mem[3], 200, 1'b0, er, ee, ea);
    run_xfer(1'b0, 32'hC, 32'h0, 200, 1'b0, 0, o);
    n_checks++;
    if (o.acc !== TMO || o.lat !== ea + 2 || o.r_err !== 1'b1 || o.r_data !== 32'h0) begin
      n_errors++;
      $display("FAIL tmo_abort: access=%0d lat=%0d err=%b data=%h required %0d %0d 1 0",
               o.acc, o.lat, o.r_err, o.r_data, TMO, ea + 2);
    end
    predict(1'b0, ref_mem[3], TMO - 1, 1'b0, er, ee, ea);
    run_xfer(1'b0, 32'hC, 32'h0, TMO - 1, 1'b0, 0, o);
    n_checks++;
    if (o.acc !== TMO || o.r_err !== 1'b0 || o.r_data !== er || o.r_err !== ee) begin
      n_errors++;
      $display("FAIL tmo_edge: access=%0d err=%b data=%h required %0d 0 %h", o.acc, o.r_err, o.r_data, TMO, er);
    end
    predict(1'b0, ref_mem[2], 0, 1'b0, er, ee, ea);
    run_xfer(1'b0, 32'h8, 32'h0, 0, 1'b0, 0, o);
    n_checks++;
    if (o.r_data !== er || o.r_err !== 1'b0 || o.lat !== 3 || o.done_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL tmo_after: data=%h err=%b lat=%0d required %h 0 3", o.r_data, o.r_err, o.lat, er);
    end
  endtask

  task automatic test_backpressure;
    obs_t o; logic [31:0] er; logic ee; int ea;
    predict(1'b0, ref_mem[1], 1, 1'b0, er, ee, ea);
    run_xfer(1'b0, 32'h4, 32'h0, 1, 1'b0, 5, o);
    n_checks++;
    if (o.held !== 1'b1 || o.r_data !== er || o.done_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_hold: held=%b data=%h done=%b required 1 %h 1", o.held, o.r_data, o.done_ok, er);
    end
  endtask

  task automatic test_slverr;
    obs_t o; logic [31:0] er; logic ee; int ea;
    predict(1'b0, ref_mem[2], 0, 1'b1, er, ee, ea);
    run_xfer(1'b0, 32'h8, 32'h0, 0, 1'b1, 2, o);
    n_checks++;
    if (o.r_err !== 1'b1 || o.r_data !== 32'h0 || o.r_err !== ee || o.r_data !== er || o.held !== 1'b1) begin
      n_errors++;
      $display("FAIL slverr: err=%b data=%h held=%b required 1 0 1", o.r_err, o.r_data, o.held);
    end
  endtask

  task automatic test_random;
    obs_t o; logic [31:0] er, wd, ad; logic ee, wr, err; int ea, idx, wn, dly, r;
    for (int t = 0; t < 30; t++) begin
      wr  = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 15);
      ad  = 32'(idx) << 2;
      wd  = $urandom;
      r   = $urandom_range(0, 9);
      wn  = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(TMO - 2, TMO + 2) : 0;
      err = ($urandom_range(0, 9) == 0);
      dly = $urandom_range(0, 3);
      predict(wr, ref_mem[idx], wn, err, er, ee, ea);
      run_xfer(wr, ad, wd, wn, err, dly, o);
      if (wr && !ee) ref_mem[idx] = wd;
      n_checks++;
      if (o.hung || o.r_data !== er || o.r_err !== ee || o.acc !== ea || o.lat !== ea + 2 ||
          !o.stable || !o.held || !o.done_ok) begin
        n_errors++;
        $display("FAIL rnd[%0d]: wr=%b a=%h w=%0d e=%b data=%h err=%b acc=%0d lat=%0d st=%b hd=%b ok=%b required data=%h err=%b acc=%0d lat=%0d",
                 t, wr, ad, wn, err, o.r_data, o.r_err, o.acc, o.lat, o.stable, o.held, o.done_ok,
                 er, ee, ea, ea + 2);
      end
    end
  endtask

  task automatic test_reset_mid;
    obs_t o; logic [31:0] er; logic ee; int ea; int guard;
    cfg_wait  = 1000;
    cfg_err   = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h14;
    cmd_valid = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin @(negedge pclk); guard++; end
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge pclk);
    n_checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      n_errors++;
      $display("FAIL rm_access: psel=%b penable=%b required 1 1", psel, penable);
    end
    #2 preset = 1'b1;
    #1;
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rm_async: psel=%b pen=%b rvld=%b crdy=%b required 0 0 0 0", psel, penable, rsp_valid, cmd_ready);
    end
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      n_errors++;
      $display("FAIL rm_release: cmd_ready=%b psel=%b required 1 0", cmd_ready, psel);
    end
    predict(1'b0, ref_mem[2], 0, 1'b0, er, ee, ea);
    run_xfer(1'b0, 32'h8, 32'h0, 0, 1'b0, 0, o);
    n_checks++;
    if (o.r_data !== er || o.r_err !== ee || o.lat !== ea + 2 || o.done_ok !== 1'b1) begin
      n_errors++;
      $display("FAIL rm_after: data=%h err=%b lat=%0d required %h %b %0d", o.r_data, o.r_err, o.lat, er, ee, ea + 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    cfg_wait  = 0;
    cfg_err   = 1'b0;
    slv_cnt   = 0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = 'z;
    for (int i = 0; i < 16; i++) begin
      slv_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    slv_mem[2] = 32'hface_5678;
    ref_mem[2] = 32'hface_5678;

    test_reset();
    test_zero_wait_write();
    test_read_reg();
    test_wait_states();
    test_timeout();
    test_backpressure();
    test_slverr();
    test_random();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (initiator) that turns single-beat command-channel requests into APB SETUP/ACCESS transfers on a peripheral bus.
- Drives register slaves such as the traffic-light controller block.
- Returns read data and an error flag on a buffered response channel.
- Bounds wait states with a timeout so a dead or absent slave cannot hang the bus.

Parameters:
- ADDR_W, 32, width of cmd_addr and paddr.
- DATA_W, 32, width of write/read data.
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- pclk  in  1  bus clock; all logic on its rising edge.
- preset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr seen or timeout.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DATA_W  APB read data; may be Z outside ACCESS.
- pready  in  1  slave ready; tie high for slaves with no wait states.
- pslverr  in  1  slave error; tie low if unused.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-transfer):
  - state = IDLE.
  - psel = penable = pwrite = 0; paddr = pwdata = 0.
  - rsp_valid = rsp_err = 0; rsp_rdata = 0; wait counter = 0.
  - cmd_ready = 1 one edge after reset deasserts; it is 0 while reset is asserted.
- FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready at edge N: latch addr, wdata and write into paddr, pwdata and pwrite; psel <= 1, penable <= 0, cmd_ready <= 0; go to SETUP.
  - In cycle N+1 the bus shows SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - penable <= 1; go to ACCESS, so cycle N+2 is the first ACCESS cycle.
- ACCESS:
  - paddr, pwdata, pwrite and psel are held stable.
  - At each edge, if pready = 1:
    - rsp_rdata <= (pwrite | pslverr) ? 0 : prdata.
    - rsp_err <= pslverr.
    - rsp_valid <= 1; psel <= 0; penable <= 0; go to RESP.
  - If pready = 0:
    - wait counter increments.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT (pready low TIMEOUT consecutive ACCESS edges): psel/penable <= 0, rsp_err <= 1, rsp_rdata <= 0, rsp_valid <= 1; go to RESP.
    - pready arriving on that same edge takes priority over the timeout.
  - prdata is sampled only on the completing edge; Z or X at any other time must not propagate.
- RESP:
  - rsp_valid and the rsp_* fields are held until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid <= 0, rsp_err <= 0, cmd_ready <= 1, counter <= 0; go to IDLE.
  - rsp_ready high in the same cycle rsp_valid rises completes the handshake on the next edge.
- Throughput:
  - Zero-wait transfer: command accept edge N, response visible in cycle N+3.
  - Next command is accepted no earlier than the edge after the response handshake.
  - At most one transfer is in flight; there are no back-to-back APB transfers.
- cmd_valid while cmd_ready = 0 is ignored; the requester must hold it.
- Wait counter is wide enough for TIMEOUT (clog2(TIMEOUT+1) bits, minimum 1).

Test Plan:
- Zero-wait write, pready = 1:
  - Stimulus: cmd write addr 0x4, wdata 0x1234_5678.
  - Required: SETUP one cycle with psel=1, penable=0, paddr=0x4, pwrite=1; ACCESS one cycle; rsp_valid in cycle N+3 with rsp_err=0 and rsp_rdata=0.
- Read against a register slave:
  - Stimulus: after reset, read 0x8.
  - Required: rsp_rdata=0xface_5678, rsp_err=0; prdata Z outside ACCESS never appears on rsp_rdata.
- Wait states:
  - Stimulus: read with pready held low 3 ACCESS cycles, slave returns 0xCAFE_0001.
  - Required: psel/penable/paddr stable for 4 ACCESS cycles; rsp_rdata=0xCAFE_0001.
- Timeout:
  - Stimulus: TIMEOUT=16, pready stuck low.
  - Required: transfer aborts after 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0; the next command proceeds normally.
  - Also: with pready rising exactly on the 16th edge, the transfer completes normally with rsp_err=0.
- Response backpressure and reset:
  - Stimulus: rsp_ready low 5 cycles.
  - Required: rsp_* held and cmd_ready=0 until the handshake.
  - Stimulus: assert preset during ACCESS.
  - Required: psel/penable/rsp_valid drop immediately (asynchronously); cmd_ready returns to 1 after release.
- pslverr:
  - Stimulus: read completes with pready=1, pslverr=1.
  - Required: rsp_err=1, rsp_rdata=0.
